rr_arbiter_8: RTL and testbench



---
 rtl/rr_arbiter_8.sv | 165 ++++++++++++++++
 tb/tb_rr_arbiter_8.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter_8.sv
// rr_arbiter_8: eight-client round-robin arbiter with a registered one-hot
// grant and binary owner index. After each grant the search starts one
// position above the last owner and wraps, so the previous owner always
// has the lowest priority.
//
// Optional feature (macro GRANT_TIMEOUT_EN): a hold counter forces a release
// after MAX_HOLD cycles of continuous ownership and pulses `timeout`.
// With the macro undefined, no counter is built and `timeout` stays 0.

module rr_arbiter_8 #(
    parameter int unsigned MAX_HOLD = 16,
    parameter int unsigned CNT_W    = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] req,
    input  logic       done,
    output logic [7:0] grant,
    output logic [2:0] grant_idx,
    output logic       grant_valid,
    output logic       timeout
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    // Rotating-priority search. Returns {hit, index}. Indices are scanned
    // from last+1 up to last+8 (last itself), with wrap mod 8. The loop runs
    // backwards so the closest requester overwrites all earlier matches.
    function automatic logic [3:0] rr_search(input logic [7:0] r, input logic [2:0] last);
        logic [3:0] res;
        logic [2:0] idx;
        res = 4'b0000;
        for (int i = 8; i >= 1; i--) begin
            idx = last + 3'(i);
            if (r[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    // Catch illegal parameter combinations at elaboration.
    if ((MAX_HOLD < 2) || (MAX_HOLD > 255) || ((2 ** CNT_W) <= MAX_HOLD)) begin : g_param_check
        $error("rr_arbiter_8: illegal MAX_HOLD/CNT_W combination");
    end

    state_t     state_q;
    logic [7:0] grant_q;
    logic [2:0] grant_idx_q;
    logic       grant_valid_q;
    logic       timeout_q;
    logic [2:0] last_owner_q;

    logic       pick_hit_s;
    logic [2:0] pick_idx_s;
    logic       tmo_hit_s;
    logic       release_s;
    logic       forced_s;

`ifdef GRANT_TIMEOUT_EN
    logic [CNT_W-1:0] hold_q;
    logic [CNT_W-1:0] hold_d;

    assign tmo_hit_s = (hold_q == CNT_W'(MAX_HOLD - 1));

    // Hold counter next value: count BUSY cycles without a release, clear otherwise.
    always_comb begin
        hold_d = '0;
        if ((state_q == ST_BUSY) && !release_s) begin
            hold_d = hold_q + CNT_W'(1);
        end else begin
            hold_d = '0;
        end
    end

    // Hold counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end
`else
    assign tmo_hit_s = 1'b0;
`endif

    // Search winner and release decision for the current cycle.
    always_comb begin
        pick_hit_s = 1'b0;
        pick_idx_s = 3'd0;
        release_s  = 1'b0;
        forced_s   = 1'b0;
        {pick_hit_s, pick_idx_s} = rr_search(req, last_owner_q);
        if (state_q == ST_BUSY) begin
            // done and withdrawal together still make one release.
            release_s = done || !req[grant_idx_q] || tmo_hit_s;
            // Only a release caused purely by the hold limit counts as forced.
            forced_s  = tmo_hit_s && !done && req[grant_idx_q];
        end else begin
            release_s = 1'b0;
            forced_s  = 1'b0;
        end
    end

    // Arbitration FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            grant_q       <= 8'h00;
            grant_idx_q   <= 3'd0;
            grant_valid_q <= 1'b0;
            timeout_q     <= 1'b0;
            last_owner_q  <= 3'd7;
        end else begin
            timeout_q <= forced_s;
            case (state_q)
                ST_IDLE: begin
                    if (pick_hit_s) begin
                        state_q       <= ST_BUSY;
                        grant_q       <= 8'h01 << pick_idx_s;
                        grant_idx_q   <= pick_idx_s;
                        grant_valid_q <= 1'b1;
                        last_owner_q  <= pick_idx_s;
                    end else begin
                        state_q       <= ST_IDLE;
                        grant_q       <= 8'h00;
                        grant_valid_q <= 1'b0;
                    end
                end
                ST_BUSY: begin
                    if (release_s && pick_hit_s) begin
                        // Back-to-back handover (or re-grant of a sole requester).
                        state_q       <= ST_BUSY;
                        grant_q       <= 8'h01 << pick_idx_s;
                        grant_idx_q   <= pick_idx_s;
                        grant_valid_q <= 1'b1;
                        last_owner_q  <= pick_idx_s;
                    end else if (release_s) begin
                        // Nobody left: go idle, keep grant_idx as the last owner.
                        state_q       <= ST_IDLE;
                        grant_q       <= 8'h00;
                        grant_valid_q <= 1'b0;
                    end else begin
                        state_q       <= ST_BUSY;
                    end
                end
                default: begin
                    state_q       <= ST_IDLE;
                    grant_q       <= 8'h00;
                    grant_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign grant       = grant_q;
    assign grant_idx   = grant_idx_q;
    assign grant_valid = grant_valid_q;
    assign timeout     = timeout_q;

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Directed, table-driven bench for rr_arbiter_8. Each vector gives the inputs
// applied before a rising edge and the outputs expected just after that edge.
// Define GRANT_TIMEOUT_EN to exercise the hold-limit path with MAX_HOLD=4.

module tb_rr_arbiter_8;

`ifdef GRANT_TIMEOUT_EN
    localparam int unsigned TB_MAX_HOLD = 4;
`else
    localparam int unsigned TB_MAX_HOLD = 16;
`endif

    typedef struct {
        logic       rst;
        logic [7:0] req;
        logic       done;
        logic [7:0] exp_grant;
        logic [2:0] exp_idx;
        logic       exp_valid;
        logic       exp_tmo;
    } vec_t;

    logic       clk;
    logic       reset;
    logic [7:0] req;
    logic       done;
    logic [7:0] grant;
    logic [2:0] grant_idx;
    logic       grant_valid;
    logic       timeout;

    int   checks;
    int   failures;
    vec_t vecs[$];

    rr_arbiter_8 #(
        .MAX_HOLD(TB_MAX_HOLD),
        .CNT_W   (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .done       (done),
        .grant      (grant),
        .grant_idx  (grant_idx),
        .grant_valid(grant_valid),
        .timeout    (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input logic r, input logic [7:0] rq, input logic d,
                       input logic [7:0] eg, input logic [2:0] ei,
                       input logic ev, input logic et);
        vec_t v;
        v.rst = r; v.req = rq; v.done = d;
        v.exp_grant = eg; v.exp_idx = ei; v.exp_valid = ev; v.exp_tmo = et;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int step,
                         input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s step %0d: got %0h expected %0h", name, step, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input int step,
                             input logic [7:0] eg, input logic [2:0] ei,
                             input logic ev, input logic et);
        check({tag, ".grant"},       step, grant, eg);
        check({tag, ".grant_idx"},   step, {5'd0, grant_idx}, {5'd0, ei});
        check({tag, ".grant_valid"}, step, {7'd0, grant_valid}, {7'd0, ev});
        check({tag, ".timeout"},     step, {7'd0, timeout}, {7'd0, et});
    endtask

    task automatic step_in(input logic r, input logic [7:0] rq, input logic d);
        reset = r; req = rq; done = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int k1;
        logic [2:0] eidx;
        logic       etmo;
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        req      = 8'h00;
        done     = 1'b0;

        // Reset, then idle with no requests; done while idle is ignored.
        add(1'b1, 8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
        add(1'b1, 8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) add(1'b0, 8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
        add(1'b0, 8'h00, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0);

        // All requesting, done every third cycle: 0,1,...,7,0 with no gaps.
        add(1'b0, 8'hFF, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0);
        for (int k = 0; k < 8; k++) begin
            k1 = (k + 1) % 8;
            add(1'b0, 8'hFF, 1'b0, 8'h01 << k, 3'(k), 1'b1, 1'b0);
            add(1'b0, 8'hFF, 1'b0, 8'h01 << k, 3'(k), 1'b1, 1'b0);
            add(1'b0, 8'hFF, 1'b1, 8'h01 << k1, 3'(k1), 1'b1, 1'b0);
        end

        // Owner 5 with req=24: other request ignored, done hands to 2, withdrawal idles.
        add(1'b0, 8'h20, 1'b1, 8'h20, 3'd5, 1'b1, 1'b0);
        add(1'b0, 8'h24, 1'b0, 8'h20, 3'd5, 1'b1, 1'b0);
        add(1'b0, 8'h24, 1'b0, 8'h20, 3'd5, 1'b1, 1'b0);
        add(1'b0, 8'h24, 1'b1, 8'h04, 3'd2, 1'b1, 1'b0);
        add(1'b0, 8'h04, 1'b0, 8'h04, 3'd2, 1'b1, 1'b0);
        add(1'b0, 8'h00, 1'b0, 8'h00, 3'd2, 1'b0, 1'b0);
        add(1'b0, 8'h00, 1'b0, 8'h00, 3'd2, 1'b0, 1'b0);

        // Sole requester 0 re-granted on done, then done+withdraw as one release.
        add(1'b0, 8'h01, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0);
        add(1'b0, 8'h01, 1'b1, 8'h01, 3'd0, 1'b1, 1'b0);
        add(1'b0, 8'h01, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0);
        add(1'b0, 8'h01, 1'b1, 8'h01, 3'd0, 1'b1, 1'b0);
        add(1'b0, 8'h01, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0);
        add(1'b0, 8'h00, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0);

        // Reset mid-grant, regrant after release, then wrap 7 -> 0.
        add(1'b0, 8'h08, 1'b0, 8'h08, 3'd3, 1'b1, 1'b0);
        add(1'b1, 8'h08, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
        add(1'b0, 8'h08, 1'b0, 8'h08, 3'd3, 1'b1, 1'b0);
        add(1'b0, 8'h09, 1'b1, 8'h01, 3'd0, 1'b1, 1'b0);
        add(1'b0, 8'h80, 1'b0, 8'h80, 3'd7, 1'b1, 1'b0);
        add(1'b0, 8'h81, 1'b1, 8'h01, 3'd0, 1'b1, 1'b0);
        add(1'b0, 8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);

        foreach (vecs[i]) begin
            step_in(vecs[i].rst, vecs[i].req, vecs[i].done);
            check_all("vec", i, vecs[i].exp_grant, vecs[i].exp_idx,
                      vecs[i].exp_valid, vecs[i].exp_tmo);
        end

        // Hold-limit sequence: req=81, done never asserted.
        step_in(1'b1, 8'h00, 1'b0);
        check_all("hold_rst", 0, 8'h00, 3'd0, 1'b0, 1'b0);
        for (int n = 1; n <= 20; n++) begin
            step_in(1'b0, 8'h81, 1'b0);
`ifdef GRANT_TIMEOUT_EN
            eidx = ((((n - 1) / 4) % 2) == 0) ? 3'd0 : 3'd7;
            etmo = (n > 1) && (((n - 1) % 4) == 0);
`else
            eidx = 3'd0;
            etmo = 1'b0;
`endif
            check_all("hold", n, 8'h01 << eidx, eidx, 1'b1, etmo);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
